// File: rtl/f5_reader.sv
// F5 buffer reader: streams N_ELEM elements from the F5 buffer to the F6 stage
// through a credit-controlled show-ahead FIFO that absorbs the buffer read latency.
module f5_reader #(
    parameter int N_ELEM     = 120,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  f5_raddr,
    output logic [3:0]  f5_sel,
    input  logic [15:0] f5_rdata,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic [8:0]  dout_idx
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
    localparam logic [9:0] N_ELEM_W  = 10'(N_ELEM);
    localparam logic [9:0] LAST_ISSUE = 10'(N_ELEM - 1);
    localparam logic [8:0] LAST_IDX  = 9'(N_ELEM - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic [9:0]        issue_cnt;
    logic [8:0]        push_cnt;
    logic [RD_LAT-1:0] inflight_sr;
    logic [15:0]       data_mem [FIFO_DEPTH];
    logic [8:0]        idx_mem  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_count, inflight, credit_used;
    logic              issue, push, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(inflight_sr[i]);
    end

    // A slot popped this cycle is already free, so it is credited back immediately;
    // this keeps one issue per cycle with FIFO_DEPTH = RD_LAT+1.
    assign push        = inflight_sr[RD_LAT-1];
    assign dout_valid  = (fifo_count != '0);
    assign pop         = dout_valid & dout_ready;
    assign credit_used = fifo_count + inflight - CW'(pop);
    assign issue       = (state == READ) && (issue_cnt < N_ELEM_W) &&
                         (credit_used < CW'(FIFO_DEPTH));

    assign dout      = data_mem[rd_ptr];
    assign dout_idx  = idx_mem[rd_ptr];
    assign dout_last = dout_valid & last_mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            issue_cnt <= '0;
            f5_raddr  <= '0;
            f5_sel    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= READ;
                        busy      <= 1'b1;
                        issue_cnt <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        f5_raddr  <= issue_cnt[8:4];
                        f5_sel    <= issue_cnt[3:0];
                        issue_cnt <= issue_cnt + 10'd1;
                        if (issue_cnt == LAST_ISSUE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && dout_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_sr <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            push_cnt    <= '0;
            last_mem    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                idx_mem[i]  <= '0;
            end
        end else begin
            inflight_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) inflight_sr[i] <= inflight_sr[i-1];

            if (push) begin
                data_mem[wr_ptr] <= f5_rdata;
                idx_mem[wr_ptr]  <= push_cnt;
                last_mem[wr_ptr] <= (push_cnt == LAST_IDX);
                wr_ptr           <= next_ptr(wr_ptr);
                push_cnt         <= push_cnt + 9'd1;
            end
            if (state == IDLE && start) push_cnt <= '0;
            if (pop) rd_ptr <= next_ptr(rd_ptr);

            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!push && pop) fifo_count <= fifo_count - CW'(1);
        end
    end
endmodule

// File: tb/tb_f5_reader.sv
// Scoreboard bench for f5_reader: a default instance exercised with steady, stalled,
// random and disrupted runs, plus a single-element instance (N_ELEM=1, RD_LAT=1).
module tb_f5_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start1, ready0, ready1;
    logic        busy0, done0, dout0_valid, dout0_last;
    logic        busy1, done1, dout1_valid, dout1_last;
    logic [4:0]  raddr0, raddr1;
    logic [3:0]  sel0, sel1;
    logic [15:0] rdata0, rdata1, dout0, dout1;
    logic [8:0]  dout0_idx, dout1_idx;

    f5_reader dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .f5_raddr(raddr0), .f5_sel(sel0), .f5_rdata(rdata0),
        .dout(dout0), .dout_valid(dout0_valid), .dout_ready(ready0),
        .dout_last(dout0_last), .dout_idx(dout0_idx)
    );

    f5_reader #(.N_ELEM(1), .RD_LAT(1), .FIFO_DEPTH(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .f5_raddr(raddr1), .f5_sel(sel1), .f5_rdata(rdata1),
        .dout(dout1), .dout_valid(dout1_valid), .dout_ready(ready1),
        .dout_last(dout1_last), .dout_idx(dout1_idx)
    );

    // Buffer models: element i holds 0x1000+i; RD_LAT-1 register stages after the address.
    logic [15:0] ram0_s1, ram0_s2;
    always @(posedge clk) begin
        ram0_s1 <= 16'h1000 + {7'd0, raddr0, sel0};
        ram0_s2 <= ram0_s1;
    end
    assign rdata0 = ram0_s2;
    assign rdata1 = 16'h1000 + {7'd0, raddr1, sel1};

    int checks = 0;
    int failures = 0;
    logic [25:0] q0[$];
    logic [25:0] q1[$];
    int hs_count0 = 0, done_count0 = 0, hs_count1 = 0, done_count1 = 0;
    bit last_hs0 = 0, prev_stall0 = 0, last_hs1 = 0;
    logic [25:0] held0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_output("rst_ctrl0", {busy0, done0, dout0_valid, dout0_last, raddr0, sel0}, 0);
        check_output("rst_data0", {dout0_idx, dout0}, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_hs0    = 0;
            prev_stall0 = 0;
        end else begin
            if (done0 || last_hs0) begin
                check_output("done0_pulse", done0, last_hs0);
                if (done0) done_count0++;
            end
            if (prev_stall0)
                check_output("stall_hold0", {dout0_valid, dout0_last, dout0_idx, dout0}, {1'b1, held0});
            last_hs0 = 0;
            if (dout0_valid && ready0) begin
                if (q0.size() == 0) check_output("extra_out0", q0.size(), 1);
                else check_output("dout0", {dout0_last, dout0_idx, dout0}, q0.pop_front());
                hs_count0++;
                last_hs0 = dout0_last;
            end
            prev_stall0 = dout0_valid && !ready0;
            held0 = {dout0_last, dout0_idx, dout0};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_hs1 = 0;
        end else begin
            if (done1 || last_hs1) begin
                check_output("done1_pulse", done1, last_hs1);
                if (done1) done_count1++;
            end
            last_hs1 = 0;
            if (dout1_valid && ready1) begin
                if (q1.size() == 0) check_output("extra_out1", q1.size(), 1);
                else check_output("dout1", {dout1_last, dout1_idx, dout1}, q1.pop_front());
                hs_count1++;
                last_hs1 = dout1_last;
            end
        end
    end

    // mode 0: ready high, 1: ready low cycles 10-29, 2: start at element 50,
    // 3: reset at element 60, 4: random ready
    task automatic apply_stimulus(input int mode, input bit check_lat);
        int e;
        int base_hs;
        int base_done;
        bit pulsed;
        bit aborted;
        for (int i = 0; i < 120; i++) q0.push_back({(i == 119), 9'(i), 16'h1000 + 16'(i)});
        base_hs   = hs_count0;
        base_done = done_count0;
        pulsed    = 0;
        aborted   = 0;
        @(posedge clk); #1; start0 = 1; ready0 = 1;
        @(posedge clk); #1; start0 = 0;
        check_output("busy_run", busy0, 1);
        e = 0;
        while (done_count0 == base_done && e < 3000) begin
            case (mode)
                1: ready0 = !(e >= 10 && e <= 29);
                4: ready0 = 1'($urandom_range(0, 1));
                default: ready0 = 1;
            endcase
            if (check_lat && e <= 4) check_output("first_valid", dout0_valid, (e == 4));
            if (mode == 1 && e == 29) begin
                check_output("freeze_addr", {raddr0, sel0}, 9'd9);
                check_output("stall_head", {dout0_valid, dout0_idx}, {1'b1, 9'd6});
            end
            if (mode == 2 && !pulsed && (hs_count0 - base_hs) >= 50) begin
                start0 = 1;
                pulsed = 1;
            end
            if (mode == 3 && (hs_count0 - base_hs) >= 60) begin
                rst = 1;
                #1;
                check_reset_outputs();
                @(posedge clk);
                @(posedge clk); #1;
                check_reset_outputs();
                rst = 0;
                q0.delete();
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            e++;
            start0 = 0;
        end
        if (!aborted) begin
            check_output("run_done", done_count0 - base_done, 1);
            check_output("busy_after_done", {busy0, done0}, 0);
            check_output("queue_drained0", q0.size(), 0);
        end else begin
            check_output("abort_no_done", done_count0 - base_done, 0);
        end
        ready0 = 1;
    endtask

    task automatic run_small();
        int e;
        int base_done;
        q1.push_back({1'b1, 9'd0, 16'h1000});
        base_done = done_count1;
        @(posedge clk); #1; start1 = 1;
        @(posedge clk); #1; start1 = 0;
        e = 0;
        while (done_count1 == base_done && e < 50) begin
            @(posedge clk); #1;
            e++;
        end
        check_output("small_done", done_count1 - base_done, 1);
        check_output("small_hs", hs_count1, 1);
        check_output("small_idle", {busy1, done1, dout1_valid}, 0);
        check_output("queue_drained1", q1.size(), 0);
    endtask

    initial begin
        rst = 1; start0 = 0; start1 = 0; ready0 = 1; ready1 = 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        check_output("rst_ctrl1", {busy1, done1, dout1_valid, dout1_last}, 0);
        rst = 0;
        apply_stimulus(0, 1);
        apply_stimulus(1, 0);
        apply_stimulus(2, 0);
        apply_stimulus(3, 0);
        apply_stimulus(0, 0);
        apply_stimulus(4, 0);
        run_small();
        check_output("total_done0", done_count0, 5);
        check_output("total_done1", done_count1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
